// File: rtl/calc_exec_if.sv
// Operand/opcode/result bundle between the calculator control FSM and calc_exec.
// The control FSM side uses modport master and the execution unit uses modport slave.
interface calc_exec_if #(
  parameter int DW = 8
);
  logic [DW-1:0]   Din;
  logic            WE;
  logic            W1;
  logic [2:0]      MS;
  logic            Done;
  logic [2*DW-1:0] Result;
  logic            Valid;
  logic            Busy;
  logic            Err;

  modport master (
    output Din, WE, W1, MS, Done,
    input  Result, Valid, Busy, Err
  );

  modport slave (
    input  Din, WE, W1, MS, Done,
    output Result, Valid, Busy, Err
  );
endinterface

// File: rtl/calc_exec.sv
// Calculator execution unit: two-entry operand file, single-cycle ALU ops and an iterative shift-add multiplier.
// Define CALC_EXEC_DIV_EN to add an unsigned restoring divider (MS=101) that shares the iterative state.
module calc_exec #(
  parameter int DW = 8
) (
  input  logic        CLK,
  input  logic        clear_n,
  calc_exec_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  logic [1:0]      state;
  logic            done_p1;
  logic [DW-1:0]   rf_a, rf_b;
  logic [2:0]      op_p1;
  logic [DW-1:0]   a_p1, b_p1;
  logic [2*DW-1:0] acc, mcand;
  logic [DW-1:0]   mplier;
  logic [CW-1:0]   cnt;
  logic [2*DW-1:0] result;
  logic            valid, busy, err;

  logic            rise;
  logic [2*DW-1:0] mul_acc_nxt;
  logic [2*DW-1:0] exec_res;
  logic            exec_err;
  logic            exec_iter;
  logic [2*DW-1:0] iter_res;

  function automatic logic [2*DW-1:0] zext(input logic [DW-1:0] v);
    return {{DW{1'b0}}, v};
  endfunction

  function automatic logic [2*DW-1:0] sub_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] d;
    d = $signed(zext(a)) - $signed(zext(b));
    return d;
  endfunction

  assign rise        = (state == IDLE) && bus.Done && !done_p1;
  assign mul_acc_nxt = mplier[0] ? (acc + mcand) : acc;

`ifdef CALC_EXEC_DIV_EN
  logic [DW-1:0] rem, quo;
  logic [DW:0]   rem_sh, rem_diff;
  logic          rem_ge;
  logic [DW-1:0] rem_nxt, quo_nxt;

  assign rem_sh   = {rem, quo[DW-1]};
  assign rem_diff = rem_sh - {1'b0, b_p1};
  assign rem_ge   = (rem_sh >= {1'b0, b_p1});
  assign rem_nxt  = rem_ge ? rem_diff[DW-1:0] : rem_sh[DW-1:0];
  assign quo_nxt  = {quo[DW-2:0], rem_ge};
  assign iter_res = (op_p1 == 3'b101) ? {rem_nxt, quo_nxt} : mul_acc_nxt;
`else
  assign iter_res = mul_acc_nxt;
`endif

  always_comb begin
    exec_res  = '0;
    exec_err  = 1'b0;
    exec_iter = 1'b0;
    case (op_p1)
      3'b000: exec_res = zext(a_p1);
      3'b001: exec_res = zext(a_p1) + zext(b_p1);
      3'b010: exec_res = sub_ext(a_p1, b_p1);
      3'b100: exec_res = zext(a_p1 ^ b_p1);
      3'b011: exec_iter = 1'b1;
`ifdef CALC_EXEC_DIV_EN
      3'b101: begin
        if (b_p1 == '0) begin
          exec_res = {a_p1, {DW{1'b1}}};
          exec_err = 1'b1;
        end else begin
          exec_iter = 1'b1;
        end
      end
`endif
      default: exec_err = 1'b1;
    endcase
  end

  // Control and architectural state
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      state   <= IDLE;
      done_p1 <= 1'b1;
      rf_a    <= '0;
      rf_b    <= '0;
      result  <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done_p1 <= bus.Done;
      case (state)
        IDLE: begin
          if (bus.WE) begin
            if (bus.W1) rf_b <= bus.Din;
            else        rf_a <= bus.Din;
          end
          if (rise) state <= EXEC;
        end
        EXEC: begin
          if (!bus.Done) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
          end else if (exec_iter) begin
            state <= MUL;
            busy  <= 1'b1;
          end else begin
            state  <= HOLD;
            result <= exec_res;
            valid  <= 1'b1;
            err    <= exec_err;
          end
        end
        MUL: begin
          // A falling Done wins over completion on the same edge
          if (!bus.Done) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
          end else if (cnt == LAST) begin
            state  <= HOLD;
            result <= iter_res;
            valid  <= 1'b1;
            busy   <= 1'b0;
            err    <= 1'b0;
          end
        end
        default: begin
          if (!bus.Done) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
          end
        end
      endcase
    end
  end

  // Latched operands and iteration datapath
  always_ff @(posedge CLK) begin
    if (rise) begin
      op_p1 <= bus.MS;
      a_p1  <= rf_a;
      b_p1  <= rf_b;
    end
    if (state == EXEC) begin
      acc    <= '0;
      mcand  <= zext(a_p1);
      mplier <= b_p1;
      cnt    <= '0;
`ifdef CALC_EXEC_DIV_EN
      rem    <= '0;
      quo    <= a_p1;
`endif
    end else if (state == MUL) begin
      acc    <= mul_acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
`ifdef CALC_EXEC_DIV_EN
      rem    <= rem_nxt;
      quo    <= quo_nxt;
`endif
    end
  end

  assign bus.Result = result;
  assign bus.Valid  = valid;
  assign bus.Busy   = busy;
  assign bus.Err    = err;

endmodule

// File: tb/tb_calc_exec.sv
// Directed bench for calc_exec (DW=8): ALU ops, multiply latency, abort, errors, async reset.
module tb_calc_exec;
  logic CLK = 1'b0;
  logic clear_n = 1'b1;
  int checks = 0;
  int failures = 0;

  calc_exec_if #(.DW(8)) bus ();
  calc_exec #(.DW(8)) dut (.CLK(CLK), .clear_n(clear_n), .bus(bus.slave));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_reg(input logic w1, input logic [7:0] val);
    bus.WE = 1'b1; bus.W1 = w1; bus.Din = val;
    tick();
    bus.WE = 1'b0;
  endtask

  // Raises Done and waits (bounded) for Valid; cyc counts edges from the Done-sampling edge
  task automatic run_op(input logic [2:0] ms, output int cyc, output int busy_cyc);
    bus.MS = ms; bus.Done = 1'b1;
    tick();
    cyc = 1; busy_cyc = 0;
    while (!bus.Valid && cyc < 30) begin
      tick();
      cyc++;
      if (bus.Busy) busy_cyc++;
    end
  endtask

  task automatic end_op();
    bus.Done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2 clear_n = 1'b0;
    #1;
    checks++;
    if (bus.Result !== 16'd0 || bus.Valid !== 1'b0 || bus.Busy !== 1'b0 || bus.Err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got R=%0d V=%b B=%b E=%b, want 0 0 0 0", bus.Result, bus.Valid, bus.Busy, bus.Err);
    end
    tick(); tick();
    bus.Done = 1'b1;
    @(negedge CLK) clear_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.Valid !== 1'b0 || bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_done_high: got V=%b B=%b, want 0 0", bus.Valid, bus.Busy);
    end
    end_op();
  endtask

  task automatic test_add();
    write_reg(1'b0, 8'd200);
    write_reg(1'b1, 8'd100);
    bus.MS = 3'b001; bus.Done = 1'b1;
    tick();
    checks++;
    if (bus.Valid !== 1'b0) begin
      failures++; $display("FAIL add_early_valid: got %b, want 0", bus.Valid);
    end
    tick();
    bus.MS = 3'b110; bus.WE = 1'b1; bus.Din = 8'd1;
    checks++;
    if (bus.Result !== 16'd300 || bus.Valid !== 1'b1 || bus.Err !== 1'b0) begin
      failures++;
      $display("FAIL add: got R=%0d V=%b E=%b, want 300 1 0", bus.Result, bus.Valid, bus.Err);
    end
    tick(); tick();
    bus.WE = 1'b0;
    checks++;
    if (bus.Result !== 16'd300 || bus.Valid !== 1'b1 || bus.Err !== 1'b0) begin
      failures++;
      $display("FAIL add_hold: got R=%0d V=%b E=%b, want 300 1 0", bus.Result, bus.Valid, bus.Err);
    end
    end_op();
    checks++;
    if (bus.Result !== 16'd300 || bus.Valid !== 1'b0) begin
      failures++;
      $display("FAIL add_release: got R=%0d V=%b, want 300 0", bus.Result, bus.Valid);
    end
  endtask

  task automatic test_sub_xor();
    int cyc, bc;
    write_reg(1'b0, 8'd5);
    write_reg(1'b1, 8'd9);
    run_op(3'b010, cyc, bc);
    checks++;
    if (bus.Result !== 16'hFFFC || cyc !== 2) begin
      failures++; $display("FAIL sub: got R=%h cyc=%0d, want fffc 2", bus.Result, cyc);
    end
    end_op();
    run_op(3'b100, cyc, bc);
    checks++;
    if (bus.Result !== 16'h000C || bus.Err !== 1'b0) begin
      failures++; $display("FAIL xor: got R=%h E=%b, want 000c 0", bus.Result, bus.Err);
    end
    end_op();
    run_op(3'b000, cyc, bc);
    checks++;
    if (bus.Result !== 16'd5 || bus.Err !== 1'b0) begin
      failures++; $display("FAIL pass: got R=%0d E=%b, want 5 0", bus.Result, bus.Err);
    end
    end_op();
  endtask

  task automatic test_mul();
    int cyc, bc;
    write_reg(1'b0, 8'd255);
    write_reg(1'b1, 8'd255);
    run_op(3'b011, cyc, bc);
    checks++;
    if (bus.Result !== 16'd65025 || cyc !== 10 || bc !== 8 || bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL mul: got R=%0d cyc=%0d busy=%0d B=%b, want 65025 10 8 0", bus.Result, cyc, bc, bus.Busy);
    end
    end_op();
    write_reg(1'b0, 8'd13);
    write_reg(1'b1, 8'd11);
    run_op(3'b011, cyc, bc);
    checks++;
    if (bus.Result !== 16'd143 || cyc !== 10) begin
      failures++; $display("FAIL mul_small: got R=%0d cyc=%0d, want 143 10", bus.Result, cyc);
    end
    end_op();
  endtask

  task automatic test_mul_abort();
    int cyc, bc;
    write_reg(1'b0, 8'd3);
    write_reg(1'b1, 8'd7);
    bus.MS = 3'b011; bus.Done = 1'b1;
    tick(); tick();
    tick(); tick(); tick();
    checks++;
    if (bus.Busy !== 1'b1) begin
      failures++; $display("FAIL abort_busy: got %b, want 1", bus.Busy);
    end
    bus.Done = 1'b0;
    tick();
    checks++;
    if (bus.Valid !== 1'b0 || bus.Busy !== 1'b0 || bus.Result !== 16'd143) begin
      failures++;
      $display("FAIL abort: got V=%b B=%b R=%0d, want 0 0 143", bus.Valid, bus.Busy, bus.Result);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (bus.Valid !== 1'b0) begin
      failures++; $display("FAIL abort_late_valid: got %b, want 0", bus.Valid);
    end
    write_reg(1'b0, 8'd42);
    run_op(3'b000, cyc, bc);
    checks++;
    if (bus.Result !== 16'd42 || bus.Valid !== 1'b1) begin
      failures++; $display("FAIL abort_write: got R=%0d V=%b, want 42 1", bus.Result, bus.Valid);
    end
    end_op();
  endtask

  task automatic test_err();
    int cyc, bc;
    write_reg(1'b0, 8'd17);
    write_reg(1'b1, 8'd5);
    run_op(3'b110, cyc, bc);
    checks++;
    if (bus.Result !== 16'd0 || bus.Err !== 1'b1 || bus.Valid !== 1'b1) begin
      failures++;
      $display("FAIL err_110: got R=%0d E=%b V=%b, want 0 1 1", bus.Result, bus.Err, bus.Valid);
    end
    end_op();
    checks++;
    if (bus.Err !== 1'b0) begin
      failures++; $display("FAIL err_clear: got %b, want 0", bus.Err);
    end
    run_op(3'b101, cyc, bc);
    checks++;
`ifdef CALC_EXEC_DIV_EN
    if (bus.Result !== 16'h0203 || bus.Err !== 1'b0 || cyc !== 10) begin
      failures++;
      $display("FAIL div: got R=%h E=%b cyc=%0d, want 0203 0 10", bus.Result, bus.Err, cyc);
    end
`else
    if (bus.Result !== 16'd0 || bus.Err !== 1'b1 || bus.Valid !== 1'b1) begin
      failures++;
      $display("FAIL div_off: got R=%h E=%b V=%b, want 0000 1 1", bus.Result, bus.Err, bus.Valid);
    end
`endif
    end_op();
  endtask

  task automatic test_reset_mid_mul();
    int cyc, bc;
    write_reg(1'b0, 8'd255);
    write_reg(1'b1, 8'd255);
    bus.MS = 3'b011; bus.Done = 1'b1;
    tick(); tick(); tick(); tick();
    #2 clear_n = 1'b0;
    #1;
    checks++;
    if (bus.Result !== 16'd0 || bus.Valid !== 1'b0 || bus.Busy !== 1'b0 || bus.Err !== 1'b0) begin
      failures++;
      $display("FAIL midmul_reset: got R=%0d V=%b B=%b E=%b, want 0 0 0 0", bus.Result, bus.Valid, bus.Busy, bus.Err);
    end
    tick();
    @(negedge CLK) clear_n = 1'b1;
    bc = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.Valid || bus.Busy) bc++;
    end
    checks++;
    if (bc !== 0) begin
      failures++; $display("FAIL midmul_restart: active cycles=%0d, want 0", bc);
    end
    end_op();
    write_reg(1'b0, 8'd6);
    write_reg(1'b1, 8'd7);
    run_op(3'b011, cyc, bc);
    checks++;
    if (bus.Result !== 16'd42 || cyc !== 10) begin
      failures++; $display("FAIL midmul_after: got R=%0d cyc=%0d, want 42 10", bus.Result, cyc);
    end
    end_op();
  endtask

  initial begin
    bus.Din = '0; bus.WE = 1'b0; bus.W1 = 1'b0; bus.MS = 3'b000; bus.Done = 1'b0;
    test_reset();
    test_add();
    test_sub_xor();
    test_mul();
    test_mul_abort();
    test_err();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
